// File: rtl/btn_filter.sv
// btn_filter: debounces a pre-synchronized button level and reports press, release and long-press events.
// Latency: press/release become visible on the edge that samples the STABLE_CYCLES-th consecutive equal level.
// Backpressure: none; outputs are free-running registered levels and one-cycle pulses.
//
// Ports:
//   clk           - single clock, all state updates on its rising edge
//   rst_n         - asynchronous active-low reset
//   btn_sync      - button level, already synchronized to clk
//   btn_level     - debounced button level
//   press_pulse   - one-cycle pulse per qualified press
//   release_pulse - one-cycle pulse per qualified release
//   long_press    - one-cycle pulse once a press has been held LONG_CYCLES cycles
//
// Optional feature: define BTN_FILTER_LONG_PRESS_EN to build the long-press counter;
// without it long_press is tied low and no long counter exists.
module btn_filter #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int LONG_CYCLES   = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_sync,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] count;

    // Qualifying edges: the sample on this edge must still match the level being
    // qualified, so a level change on the qualifying edge falls into the abort path.
    logic press_qual;
    logic release_qual;

    assign press_qual   = (state == PRESS_WAIT)   &&  btn_sync && (count == CNT_LAST);
    assign release_qual = (state == RELEASE_WAIT) && !btn_sync && (count == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state <= PRESS_WAIT;
                        count <= CW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (press_qual) begin
                        state       <= HELD;
                        count       <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                HELD: begin
                    if (!btn_sync) begin
                        state <= RELEASE_WAIT;
                        count <= CW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_sync) begin
                        // Glitch during release: fall back to held, level stays high.
                        state <= HELD;
                        count <= '0;
                    end else if (release_qual) begin
                        state         <= IDLE;
                        count         <= '0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

`ifdef BTN_FILTER_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);

    logic [LW-1:0] long_count;

    // Counts cycles spent held (including release qualification); it saturates at
    // LONG_CYCLES so the pulse fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_count <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (press_qual || release_qual) begin
                long_count <= '0;
            end else if (((state == HELD) || (state == RELEASE_WAIT)) && (long_count < LONG_MAX)) begin
                long_count <= long_count + LW'(1);
                if (long_count == LONG_MAX - LW'(1)) begin
                    long_press <= 1'b1;
                end
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_filter.sv
// tb_btn_filter: directed stimulus with a scoreboard queue for btn_filter (STABLE_CYCLES=4, LONG_CYCLES=10).
// Stimulus drives on the falling edge and queues the hand-computed outputs for the next rising edge.
// A separate monitor pops and compares one entry just after every rising edge.
module tb_btn_filter;

    logic clk;
    logic rst_n;
    logic btn_sync;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    btn_filter #(
        .STABLE_CYCLES(4),
        .LONG_CYCLES  (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_sync     (btn_sync),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press)
    );

    // Expected output bits: {btn_level, press_pulse, release_pulse, long_press}
    typedef struct {
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   vectors;
    int   miscompares;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: outputs are presented every cycle, so one entry is consumed per rising edge.
    initial begin
        exp_t       e;
        logic [3:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e   = sbq.pop_front();
                got = {btn_level, press_pulse, release_pulse, long_press};
                vectors++;
                if (got !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got lvl/prs/rel/long=%b, required %b", e.name, $time, got, e.exp);
                end
            end
        end
    end

    task automatic step(input logic r, input logic b, input logic [3:0] e, input string nm);
        exp_t x;
        @(negedge clk);
        rst_n    = r;
        btn_sync = b;
        x.exp    = e;
`ifndef BTN_FILTER_LONG_PRESS_EN
        x.exp[0] = 1'b0;
`endif
        x.name   = nm;
        sbq.push_back(x);
    endtask

    task automatic check_now(input string nm);
        logic [3:0] got;
        got = {btn_level, press_pulse, release_pulse, long_press};
        vectors++;
        if (got !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s @%0t: got lvl/prs/rel/long=%b, required 0000", nm, $time, got);
        end
    endtask

    task automatic repeat_step(input int n, input logic r, input logic b, input logic [3:0] e, input string nm);
        for (int i = 0; i < n; i++) begin
            step(r, b, e, nm);
        end
    endtask

    initial begin
        int guard;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        btn_sync    = 1'b0;
        #2;
        check_now("reset_init");

        repeat_step(2, 1'b0, 1'b0, 4'b0000, "in_reset");
        repeat_step(2, 1'b1, 1'b0, 4'b0000, "idle");

        // Clean press, long press and no repeat over 50 further held cycles
        repeat_step(3, 1'b1, 1'b1, 4'b0000, "clean_wait");
        step(1'b1, 1'b1, 4'b1100, "clean_press");
        repeat_step(9, 1'b1, 1'b1, 4'b1000, "hold_pre_long");
        step(1'b1, 1'b1, 4'b1001, "long_pulse");
        repeat_step(50, 1'b1, 1'b1, 4'b1000, "long_no_repeat");

        // Release glitch, then a clean release
        repeat_step(3, 1'b1, 1'b0, 4'b1000, "rel_wait");
        step(1'b1, 1'b1, 4'b1000, "rel_glitch");
        repeat_step(3, 1'b1, 1'b0, 4'b1000, "rel_wait2");
        step(1'b1, 1'b0, 4'b0010, "release");
        step(1'b1, 1'b0, 4'b0000, "idle_after_rel");

        // Bounce during press qualification
        repeat_step(3, 1'b1, 1'b1, 4'b0000, "bounce_wait");
        step(1'b1, 1'b0, 4'b0000, "bounce_low");
        repeat_step(3, 1'b1, 1'b1, 4'b0000, "bounce_wait2");
        step(1'b1, 1'b1, 4'b1100, "bounce_press");
        repeat_step(5, 1'b1, 1'b1, 4'b1000, "hold_pre_rst");

        // Reset mid-hold with long count at 5; button held through reset
        step(1'b0, 1'b1, 4'b0000, "rst_mid_hold");
        #1;
        check_now("rst_immediate");
        step(1'b0, 1'b1, 4'b0000, "rst_held");
        repeat_step(3, 1'b1, 1'b1, 4'b0000, "post_rst_wait");
        step(1'b1, 1'b1, 4'b1100, "fresh_press");
        repeat_step(9, 1'b1, 1'b1, 4'b1000, "hold2_pre_long");
        step(1'b1, 1'b1, 4'b1001, "long_pulse2");
        repeat_step(3, 1'b1, 1'b1, 4'b1000, "hold2_after");
        repeat_step(3, 1'b1, 1'b0, 4'b1000, "rel_wait3");
        step(1'b1, 1'b0, 4'b0010, "release2");
        step(1'b1, 1'b0, 4'b0000, "idle_end");

        guard = 0;
        while (sbq.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sbq.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d entries left unchecked, required 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_filter.md
BTN_FILTER -- requirements
Module: btn_filter

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000000, the number of consecutive equal samples that qualifies a level change; legal values are 2 or greater.
REQ-002 SHALL have parameter LONG_CYCLES, default 100000000, the held-time threshold for a long press, counted in cycles after press qualification; legal values are 1 or greater.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port btn_sync, input, 1 bit: button level, already 2FF-synchronized upstream to clk.
REQ-006 SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-007 SHALL have port press_pulse, output, 1 bit: one-cycle pulse on each qualified press.
REQ-008 SHALL have port release_pulse, output, 1 bit: one-cycle pulse on each qualified release.
REQ-009 SHALL have port long_press, output, 1 bit: one-cycle pulse when a press has been held for LONG_CYCLES.

Function
REQ-010 SHALL implement a four-state FSM: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; all outputs registered.
REQ-011 SHALL keep a stable counter sized to hold STABLE_CYCLES; it holds the number of consecutive qualifying samples taken in the current WAIT state.
REQ-012 IDLE, btn_sync=1 sampled: SHALL go to PRESS_WAIT with count=1; btn_sync=0: SHALL stay in IDLE.
REQ-013 PRESS_WAIT, btn_sync=0: SHALL return to IDLE, clear count, assert no outputs.
REQ-014 PRESS_WAIT, btn_sync=1 with count=STABLE_CYCLES-1: SHALL enter HELD on that edge, set btn_level=1 and press_pulse=1, and clear count. The press therefore becomes visible on the same edge that samples the STABLE_CYCLES-th consecutive high.
REQ-015 Otherwise in PRESS_WAIT, btn_sync=1: SHALL increment count.
REQ-016 HELD and RELEASE_WAIT SHALL mirror REQ-012 to REQ-015 with btn_sync inverted:
  - HELD to RELEASE_WAIT on the first sampled low.
  - Any high sample in RELEASE_WAIT returns to HELD with count cleared, no pulses, btn_level held at 1.
  - The STABLE_CYCLES-th consecutive low enters IDLE, sets btn_level=0 and release_pulse=1.
REQ-017 press_pulse and release_pulse SHALL be high for exactly one cycle per transition and never high together.
REQ-018 Simultaneous events: btn_sync changing on the qualifying edge SHALL be treated as a non-qualifying sample (the abort path), never as a qualification.
REQ-019 The stable counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-020 rst_n=0 SHALL immediately force:
  - FSM to IDLE;
  - both counters to 0;
  - btn_level, press_pulse, release_pulse and long_press to 0.
  This is independent of clk.
REQ-021 Reset asserted mid-qualification or mid-hold SHALL discard progress; no pulse SHALL be emitted on reset entry or exit.
REQ-022 After rst_n deasserts, the first rising edge SHALL sample btn_sync normally. A button already held through reset SHALL qualify as a fresh press.

Configuration
REQ-023 Macro BTN_FILTER_LONG_PRESS_EN SHALL compile the long-press feature in or out.
REQ-024 Macro defined:
  - A long counter SHALL clear on entry to HELD from PRESS_WAIT.
  - It SHALL increment each cycle in HELD or RELEASE_WAIT.
  - long_press SHALL pulse for one cycle when the count reaches LONG_CYCLES.
  - The counter SHALL then saturate with no repeat pulse.
  - The counter SHALL clear on entering IDLE.
REQ-025 Macro undefined: long_press SHALL be tied to 0, and no long counter SHALL exist.

Verification
Bench parameters: STABLE_CYCLES=4, LONG_CYCLES=10.
REQ-026 Clean press: btn_sync 0 to 1 and held -> btn_level rises and press_pulse is high for 1 cycle, both on the 4th sampled high edge.
REQ-027 Bounce: btn_sync pattern 1,1,1,0,1,1,1,1 -> no pulse through the 0; press_pulse on the edge sampling the final 1.
REQ-028 Release glitch: in HELD, lows 0,0,0 then 1 -> btn_level stays 1, no release_pulse; then 4 lows -> release_pulse for 1 cycle, btn_level=0.
REQ-029 Long press (macro defined): hold after qualification -> long_press pulses once, 10 cycles after press_pulse, with no repeat over 50 more held cycles. Macro undefined: long_press stays 0 throughout.
REQ-030 Reset mid-hold: rst_n=0 while HELD with long count 5 -> all outputs 0 immediately. Release rst_n with btn_sync=1 -> press_pulse on the 4th edge.
